lsq_ctrl: RTL and testbench

LSQ_CTRL -- requirements
Module: lsq_ctrl

---
 rtl/lsq_pkg.sv | 27 ++
 rtl/lsq_ctrl_if.sv | 55 +++++
 rtl/lsq_alloc.sv | 41 ++++
 rtl/lsq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_lsq_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsq_pkg.sv
// Shared types and constants for the load/store queue controller.
package lsq_pkg;

    // Default geometry of the queue.
    localparam int DEF_INDEX_WIDTH  = 5;
    localparam int DEF_OPRAND_WIDTH = 32;
    localparam int DEF_DISP_W       = 2;

    // Load/store type encoding: bit 2 distinguishes stores from loads.
    localparam int LS_TYPE_W         = 3;
    localparam int LS_TYPE_STORE_BIT = 2;

    typedef logic [LS_TYPE_W-1:0] ls_type_t;

    // Per-entry control state. The store data of each entry lives in a
    // separate array so it can map onto block RAM with a registered read.
    typedef struct packed {
        logic     valid;
        logic     ready;
        ls_type_t ls_type;
    } lsq_entry_t;

    function automatic logic is_store(input ls_type_t t);
        return t[LS_TYPE_STORE_BIT];
    endfunction

endpackage

// File: rtl/lsq_ctrl_if.sv
// Bundle of dispatch, address, commit, flush and status signals of the LSQ.
interface lsq_ctrl_if
    import lsq_pkg::*;
#(
    parameter int LSQ_INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int OPRAND_WIDTH    = DEF_OPRAND_WIDTH,
    parameter int DISP_W          = DEF_DISP_W
);
    logic [DISP_W-1:0]                      ls_valid;
    logic [DISP_W-1:0][LS_TYPE_W-1:0]       ls_type;
    logic [DISP_W-1:0][LSQ_INDEX_WIDTH-1:0] ls_entry;
    logic                                   enq_ready;

    logic                                   addr_valid;
    logic [LSQ_INDEX_WIDTH-1:0]             addr_entry;
    logic [OPRAND_WIDTH-1:0]                store_data;

    logic                                   commit_valid;
    logic [LSQ_INDEX_WIDTH-1:0]             commit_entry;

    logic                                   flush_valid;
    logic [LSQ_INDEX_WIDTH-1:0]             flush_entry;

    logic [LSQ_INDEX_WIDTH-1:0]             head_entry;
    logic                                   head_ready;
    logic                                   head_is_store;

    logic                                   cmt_out_valid;
    logic                                   cmt_out_store;
    logic [OPRAND_WIDTH-1:0]                cmt_out_data;

    logic [LSQ_INDEX_WIDTH:0]               count;
    logic                                   full;
    logic                                   empty;
    logic                                   commit_err;

    // Pipeline side: drives requests, observes queue state.
    modport master (
        output ls_valid, ls_type, addr_valid, addr_entry, store_data,
               commit_valid, commit_entry, flush_valid, flush_entry,
        input  ls_entry, enq_ready, head_entry, head_ready, head_is_store,
               cmt_out_valid, cmt_out_store, cmt_out_data,
               count, full, empty, commit_err
    );

    // Queue side.
    modport slave (
        input  ls_valid, ls_type, addr_valid, addr_entry, store_data,
               commit_valid, commit_entry, flush_valid, flush_entry,
        output ls_entry, enq_ready, head_entry, head_ready, head_is_store,
               cmt_out_valid, cmt_out_store, cmt_out_data,
               count, full, empty, commit_err
    );

endinterface

// File: rtl/lsq_alloc.sv
// Dispatch allocator: per-lane entry indices, accepted lanes and enq_ready.
module lsq_alloc
    import lsq_pkg::*;
#(
    parameter int LSQ_INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int DISP_W          = DEF_DISP_W
) (
    input  logic [LSQ_INDEX_WIDTH-1:0]             tail_i,
    input  logic [LSQ_INDEX_WIDTH:0]               count_i,
    input  logic [DISP_W-1:0]                      ls_valid_i,
    output logic [DISP_W-1:0][LSQ_INDEX_WIDTH-1:0] ls_entry_o,
    output logic [DISP_W-1:0]                      lane_accept_o,
    output logic [LSQ_INDEX_WIDTH:0]               n_acc_o,
    output logic                                   enq_ready_o
);
    localparam logic [LSQ_INDEX_WIDTH:0] DEPTH_CNT = (LSQ_INDEX_WIDTH+1)'(1 << LSQ_INDEX_WIDTH);
    localparam logic [LSQ_INDEX_WIDTH:0] DISP_CNT  = (LSQ_INDEX_WIDTH+1)'(DISP_W);

    logic [LSQ_INDEX_WIDTH:0] free_cnt;

    // Only the registered occupancy decides readiness, so a same-cycle
    // commit never opens room for a same-cycle enqueue.
    assign free_cnt    = DEPTH_CNT - count_i;
    assign enq_ready_o = (free_cnt >= DISP_CNT);

    // Lane i always points at tail+i; a lane is taken only if it and every
    // lower lane request, which keeps the tail advance contiguous.
    for (genvar gi = 0; gi < DISP_W; gi++) begin : g_lane
        assign ls_entry_o[gi]    = tail_i + LSQ_INDEX_WIDTH'(gi);
        assign lane_accept_o[gi] = enq_ready_o & (&ls_valid_i[gi:0]);
    end

    // Number of lanes accepted this cycle.
    always_comb begin
        n_acc_o = '0;
        for (int l = 0; l < DISP_W; l++) begin
            n_acc_o = n_acc_o + (LSQ_INDEX_WIDTH+1)'(lane_accept_o[l]);
        end
    end

endmodule

// File: rtl/lsq_ctrl.sv
// Circular load/store queue: multi-lane enqueue, address update, in-order
// commit and tail flush.
module lsq_ctrl
    import lsq_pkg::*;
#(
    parameter int LSQ_INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int OPRAND_WIDTH    = DEF_OPRAND_WIDTH,
    parameter int DISP_W          = DEF_DISP_W
) (
    input  logic      clk,
    input  logic      rst,
    lsq_ctrl_if.slave lsq_bus
);
    localparam int IW    = LSQ_INDEX_WIDTH;
    localparam int DEPTH = 1 << IW;
    localparam logic [IW:0] DEPTH_CNT = (IW+1)'(DEPTH);

    typedef logic [IW-1:0] idx_t;

    idx_t                  head_q, head_d;
    idx_t                  tail_q, tail_d;
    logic [IW:0]           count_q, count_d;
    lsq_entry_t            entry_q [DEPTH];
    lsq_entry_t            entry_d [DEPTH];
    logic [OPRAND_WIDTH-1:0] data_mem [DEPTH];

    logic                  cmt_out_valid_q;
    logic                  cmt_out_store_q;
    logic [OPRAND_WIDTH-1:0] cmt_out_data_q;
    logic                  commit_err_q;

    logic [DISP_W-1:0][IW-1:0] lane_entry;
    logic [DISP_W-1:0]     lane_accept;
    logic [DISP_W-1:0]     enq_fire;
    logic [IW:0]           n_acc;
    logic                  enq_ready;

    logic                  commit_ok;
    idx_t                  head_new;
    idx_t                  flush_tgt;
    idx_t                  flush_off;
    logic [DEPTH-1:0]      squash_vec;
    logic                  addr_ok;

    lsq_alloc #(
        .LSQ_INDEX_WIDTH (IW),
        .DISP_W          (DISP_W)
    ) u_alloc (
        .tail_i        (tail_q),
        .count_i       (count_q),
        .ls_valid_i    (lsq_bus.ls_valid),
        .ls_entry_o    (lane_entry),
        .lane_accept_o (lane_accept),
        .n_acc_o       (n_acc),
        .enq_ready_o   (enq_ready)
    );

    // A flush in the same cycle drops every enqueue lane.
    assign enq_fire = lane_accept & {DISP_W{~lsq_bus.flush_valid}};

    // Commit retires only the oldest entry, and only once its address is in.
    assign commit_ok = lsq_bus.commit_valid
                     && (lsq_bus.commit_entry == head_q)
                     && entry_q[head_q].valid
                     && entry_q[head_q].ready;

    assign head_new = commit_ok ? head_q + idx_t'(1) : head_q;

    // Commit is applied before flush. Flushing the entry just committed
    // means flushing everything behind it, i.e. flushing from the new head.
    assign flush_tgt = (commit_ok && (lsq_bus.flush_entry == head_q)) ? head_new
                                                                       : lsq_bus.flush_entry;
    assign flush_off = flush_tgt - head_new;

    // An entry is squashed when its age (distance from the head) is at
    // least the flush point's age; ages make wrap-around and full queues
    // behave uniformly.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_squash
        idx_t ent_off;
        assign ent_off        = idx_t'(gi) - head_new;
        assign squash_vec[gi] = lsq_bus.flush_valid && (ent_off >= flush_off);
    end

    assign addr_ok = lsq_bus.addr_valid
                   && entry_q[lsq_bus.addr_entry].valid
                   && !squash_vec[lsq_bus.addr_entry];

    // Next-state of every entry: address update, retire, squash, then allocate.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            entry_d[j] = entry_q[j];
            if (addr_ok && (lsq_bus.addr_entry == idx_t'(j))) begin
                entry_d[j].ready = 1'b1;
            end
            if (commit_ok && (head_q == idx_t'(j))) begin
                entry_d[j].valid = 1'b0;
            end
            if (squash_vec[j]) begin
                entry_d[j].valid = 1'b0;
                entry_d[j].ready = 1'b0;
            end
            for (int l = 0; l < DISP_W; l++) begin
                if (enq_fire[l] && (lane_entry[l] == idx_t'(j))) begin
                    entry_d[j].valid   = 1'b1;
                    entry_d[j].ready   = 1'b0;
                    entry_d[j].ls_type = lsq_bus.ls_type[l];
                end
            end
        end
    end

    // Next-state of head, tail and occupancy.
    always_comb begin
        head_d  = head_new;
        tail_d  = tail_q;
        count_d = count_q;
        if (lsq_bus.flush_valid) begin
            tail_d  = flush_tgt;
            count_d = {1'b0, flush_off};
        end else begin
            tail_d  = tail_q + n_acc[IW-1:0];
            count_d = count_q + n_acc - (IW+1)'(commit_ok);
        end
    end

    // Pointer, entry-flag and retire-output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                entry_q[j] <= '0;
            end
            cmt_out_valid_q <= 1'b0;
            cmt_out_store_q <= 1'b0;
            cmt_out_data_q  <= '0;
            commit_err_q    <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int j = 0; j < DEPTH; j++) begin
                entry_q[j] <= entry_d[j];
            end
            cmt_out_valid_q <= commit_ok;
            if (commit_ok) begin
                cmt_out_store_q <= is_store(entry_q[head_q].ls_type);
                cmt_out_data_q  <= data_mem[head_q];
            end
            commit_err_q <= lsq_bus.commit_valid && !commit_ok;
        end
    end

    // Store-data RAM, written on a successful address update.
    always_ff @(posedge clk) begin
        if (!rst && addr_ok) begin
            data_mem[lsq_bus.addr_entry] <= lsq_bus.store_data;
        end
    end

    assign lsq_bus.ls_entry      = lane_entry;
    assign lsq_bus.enq_ready     = enq_ready;
    assign lsq_bus.head_entry    = head_q;
    assign lsq_bus.head_ready    = (count_q != '0) && entry_q[head_q].valid && entry_q[head_q].ready;
    assign lsq_bus.head_is_store = entry_q[head_q].valid && is_store(entry_q[head_q].ls_type);
    assign lsq_bus.cmt_out_valid = cmt_out_valid_q;
    assign lsq_bus.cmt_out_store = cmt_out_store_q;
    assign lsq_bus.cmt_out_data  = cmt_out_data_q;
    assign lsq_bus.count         = count_q;
    assign lsq_bus.full          = (count_q == DEPTH_CNT);
    assign lsq_bus.empty         = (count_q == '0);
    assign lsq_bus.commit_err    = commit_err_q;

endmodule

// File: tb/tb_lsq_ctrl.sv
// Directed bench for lsq_ctrl: a vector table plus hand-written sequences
// for fill, wrap-around flush and reset during activity.
module tb_lsq_ctrl;
    import lsq_pkg::*;

    localparam int IW    = 5;
    localparam int OW    = 32;
    localparam int DW    = 2;
    localparam int DEPTH = 32;
    localparam int NVEC  = 15;

    // Inputs for one cycle, then the state expected after that clock edge.
    typedef struct {
        int lv; int lt; int av; int ae; int sd; int cv; int ce; int fv; int fe;
        int e_cnt; int e_head; int e_tail; int e_hr; int e_hs;
        int e_cv; int e_cs; int e_cd; int e_err; int chk_tail;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsq_ctrl_if #(.LSQ_INDEX_WIDTH(IW), .OPRAND_WIDTH(OW), .DISP_W(DW)) bus ();

    lsq_ctrl #(.LSQ_INDEX_WIDTH(IW), .OPRAND_WIDTH(OW), .DISP_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .lsq_bus (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.ls_valid     = '0;
        bus.ls_type      = '0;
        bus.addr_valid   = 1'b0;
        bus.addr_entry   = '0;
        bus.store_data   = '0;
        bus.commit_valid = 1'b0;
        bus.commit_entry = '0;
        bus.flush_valid  = 1'b0;
        bus.flush_entry  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One transaction: drive the given requests for a single clock, then release.
    task automatic xact(input string tag, input int lv, input int lt, input int av, input int ae,
                        input int sd, input int cv, input int ce, input int fv, input int fe);
        bus.ls_valid     = 2'(lv);
        bus.ls_type      = 6'(lt);
        bus.addr_valid   = 1'(av);
        bus.addr_entry   = 5'(ae);
        bus.store_data   = 32'(sd);
        bus.commit_valid = 1'(cv);
        bus.commit_entry = 5'(ce);
        bus.flush_valid  = 1'(fv);
        bus.flush_entry  = 5'(fe);
        tick();
        idle();
        $display("%s: count=%0d head=%0d tail=%0d cmt_v=%0b err=%0b", tag, bus.count,
                 bus.head_entry, bus.ls_entry[0], bus.cmt_out_valid, bus.commit_err);
    endtask

    // Occupancy, pointers and the flags that follow from the expected count.
    task automatic chk_state(input string tag, input int cnt, input int head, input int tail,
                             input int chk_tail);
        chk({tag, " count"}, 32'(bus.count), 32'(cnt));
        chk({tag, " head_entry"}, 32'(bus.head_entry), 32'(head));
        chk({tag, " empty"}, 32'(bus.empty), 32'(cnt == 0));
        chk({tag, " full"}, 32'(bus.full), 32'(cnt == DEPTH));
        chk({tag, " enq_ready"}, 32'(bus.enq_ready), 32'((DEPTH - cnt) >= DW));
        if (chk_tail != 0) begin
            chk({tag, " ls_entry0"}, 32'(bus.ls_entry[0]), 32'(tail));
            chk({tag, " ls_entry1"}, 32'(bus.ls_entry[1]), 32'((tail + 1) % DEPTH));
        end
    endtask

    initial begin
        //            lv lt        av ae sd            cv ce fv fe | cnt hd tl hr hs cv cs cd            err ct
        vecs[0]  = '{3, 32,       0, 0, 0,            0, 0, 0, 0,   2,  0, 2, 0, 0, 0, 0, 0,            0, 1};
        vecs[1]  = '{0, 0,        1, 1, 32'hDEADBEEF, 0, 0, 0, 0,   2,  0, 2, 0, 0, 0, 0, 0,            0, 1};
        vecs[2]  = '{0, 0,        0, 0, 0,            1, 0, 0, 0,   2,  0, 2, 0, 0, 0, 0, 0,            1, 1};
        vecs[3]  = '{0, 0,        1, 0, 32'h12345678, 0, 0, 0, 0,   2,  0, 2, 1, 0, 0, 0, 0,            0, 1};
        vecs[4]  = '{0, 0,        0, 0, 0,            1, 0, 0, 0,   1,  1, 2, 1, 1, 1, 0, 32'h12345678, 0, 1};
        vecs[5]  = '{0, 0,        0, 0, 0,            1, 1, 0, 0,   0,  2, 2, 0, 0, 1, 1, 32'hDEADBEEF, 0, 1};
        vecs[6]  = '{0, 0,        0, 0, 0,            0, 0, 0, 0,   0,  2, 2, 0, 0, 0, 0, 0,            0, 1};
        vecs[7]  = '{0, 0,        0, 0, 0,            1, 2, 0, 0,   0,  2, 2, 0, 0, 0, 0, 0,            1, 1};
        vecs[8]  = '{3, 8,        0, 0, 0,            0, 0, 0, 0,   2,  2, 4, 0, 0, 0, 0, 0,            0, 1};
        vecs[9]  = '{3, 36,       0, 0, 0,            0, 0, 1, 3,   1,  2, 3, 0, 0, 0, 0, 0,            0, 1};
        vecs[10] = '{0, 0,        1, 2, 32'hA5,       0, 0, 0, 0,   1,  2, 3, 1, 0, 0, 0, 0,            0, 1};
        vecs[11] = '{0, 0,        0, 0, 0,            1, 2, 1, 3,   0,  3, 3, 0, 0, 1, 0, 32'hA5,       0, 1};
        vecs[12] = '{3, 44,       0, 0, 0,            0, 0, 0, 0,   2,  3, 5, 0, 1, 0, 0, 0,            0, 1};
        vecs[13] = '{0, 0,        1, 3, 32'h77,       1, 3, 0, 0,   2,  3, 5, 1, 1, 0, 0, 0,            1, 1};
        vecs[14] = '{0, 0,        0, 0, 0,            1, 3, 1, 3,   0,  4, 0, 0, 0, 1, 1, 32'h77,       0, 0};

        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        $display("reset: count=%0d empty=%0b", bus.count, bus.empty);
        chk_state("reset", 0, 0, 0, 1);
        chk("reset head_ready", 32'(bus.head_ready), 32'd0);
        chk("reset cmt_out_valid", 32'(bus.cmt_out_valid), 32'd0);
        chk("reset cmt_out_store", 32'(bus.cmt_out_store), 32'd0);
        chk("reset cmt_out_data", bus.cmt_out_data, 32'd0);
        chk("reset commit_err", 32'(bus.commit_err), 32'd0);

        // Vector table.
        for (int i = 0; i < NVEC; i++) begin
            xact($sformatf("vec%0d", i), vecs[i].lv, vecs[i].lt, vecs[i].av, vecs[i].ae,
                 vecs[i].sd, vecs[i].cv, vecs[i].ce, vecs[i].fv, vecs[i].fe);
            chk_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_head, vecs[i].e_tail,
                      vecs[i].chk_tail);
            chk($sformatf("vec%0d head_ready", i), 32'(bus.head_ready), 32'(vecs[i].e_hr));
            chk($sformatf("vec%0d cmt_out_valid", i), 32'(bus.cmt_out_valid), 32'(vecs[i].e_cv));
            chk($sformatf("vec%0d commit_err", i), 32'(bus.commit_err), 32'(vecs[i].e_err));
            if (vecs[i].e_cnt != 0) begin
                chk($sformatf("vec%0d head_is_store", i), 32'(bus.head_is_store), 32'(vecs[i].e_hs));
            end
            if (vecs[i].e_cv != 0) begin
                chk($sformatf("vec%0d cmt_out_store", i), 32'(bus.cmt_out_store), 32'(vecs[i].e_cs));
                chk($sformatf("vec%0d cmt_out_data", i), bus.cmt_out_data, 32'(vecs[i].e_cd));
            end
        end

        // Fill with 16 dual enqueues, then a rejected 17th.
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            xact($sformatf("fill%0d", k), 3, k, 0, 0, 0, 0, 0, 0, 0);
            chk_state($sformatf("fill%0d", k), 2 * k, 0, (2 * k) % DEPTH, 1);
        end
        xact("fill17", 3, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_state("fill17", 32, 0, 0, 1);

        // Commit from a full queue with an enqueue attempt: nothing enters.
        xact("full_addr0", 0, 0, 1, 0, 32'h1000, 0, 0, 0, 0);
        xact("full_cmt_enq", 3, 0, 0, 0, 0, 1, 0, 0, 0);
        chk_state("full_cmt_enq", 31, 1, 0, 1);
        chk("full_cmt_enq cmt_out_valid", 32'(bus.cmt_out_valid), 32'd1);
        chk("full_cmt_enq cmt_out_store", 32'(bus.cmt_out_store), 32'd0);
        chk("full_cmt_enq cmt_out_data", bus.cmt_out_data, 32'h1000);
        xact("cnt31_enq", 3, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_state("cnt31_enq", 31, 1, 0, 1);

        // Drain entries 1..29 so the head sits at 30.
        for (int e = 1; e <= 29; e++) begin
            xact($sformatf("drain_addr%0d", e), 0, 0, 1, e, e + 32'h100, 0, 0, 0, 0);
            xact($sformatf("drain_cmt%0d", e), 0, 0, 0, 0, 0, 1, e, 0, 0);
            chk($sformatf("drain%0d cmt_out_data", e), bus.cmt_out_data, 32'(e + 32'h100));
        end
        chk_state("head30", 2, 30, 0, 1);

        // Wrap the tail to 4, then flush back to entry 1.
        xact("wrap_enq_a", 3, 0, 0, 0, 0, 0, 0, 0, 0);
        xact("wrap_enq_b", 3, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_state("wrapped", 6, 30, 4, 1);
        xact("wrap_flush1", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk_state("wrap_flush1", 3, 30, 1, 1);
        for (int s = 0; s < 3; s++) begin
            int e;
            e = (30 + s) % DEPTH;
            xact($sformatf("wrap_addr%0d", e), 0, 0, 1, e, 32'h200 + e, 0, 0, 0, 0);
            xact($sformatf("wrap_cmt%0d", e), 0, 0, 0, 0, 0, 1, e, 0, 0);
            chk($sformatf("wrap_cmt%0d cmt_out_valid", e), 32'(bus.cmt_out_valid), 32'd1);
        end
        chk_state("wrap_drained", 0, 1, 1, 1);
        chk("wrap_drained head_ready", 32'(bus.head_ready), 32'd0);
        xact("wrap_cmt_squashed", 0, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("wrap_cmt_squashed commit_err", 32'(bus.commit_err), 32'd1);
        chk("wrap_cmt_squashed cmt_out_valid", 32'(bus.cmt_out_valid), 32'd0);

        // Reset dominates enqueue, address, commit and flush in the same cycle.
        do_reset();
        xact("rst_enq", 3, 32, 0, 0, 0, 0, 0, 0, 0);
        xact("rst_addr0", 0, 0, 1, 0, 32'hCAFE, 0, 0, 0, 0);
        xact("rst_cmt0", 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("rst_cmt0 cmt_out_data", bus.cmt_out_data, 32'hCAFE);
        xact("rst_addr1", 0, 0, 1, 1, 32'hBEEF, 0, 0, 0, 0);
        rst = 1'b1;
        xact("rst_busy", 3, 0, 1, 0, 32'h55, 1, 1, 1, 1);
        rst = 1'b0;
        chk_state("rst_busy", 0, 0, 0, 1);
        chk("rst_busy head_ready", 32'(bus.head_ready), 32'd0);
        chk("rst_busy cmt_out_valid", 32'(bus.cmt_out_valid), 32'd0);
        chk("rst_busy cmt_out_store", 32'(bus.cmt_out_store), 32'd0);
        chk("rst_busy cmt_out_data", bus.cmt_out_data, 32'd0);
        chk("rst_busy commit_err", 32'(bus.commit_err), 32'd0);
        xact("rst_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_state("rst_after", 0, 0, 0, 1);
        chk("rst_after cmt_out_valid", 32'(bus.cmt_out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
